// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: reset PC default, instruction size,
// FSM state encoding and the fetch buffer entry layout.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer holding instruction/pc pairs; supports push and pop in
// the same cycle even when full, and a flush that empties it in one cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; stale entries are never visible
  // because consumers gate the head with empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues sequential fetches into a small buffer,
// handles redirects with flush/squash, and halts on a misaligned target.
module fetch_controller
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        fault
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   req_pc_q;
  logic          inflight_q;
  logic          fault_q;
  logic          misaligned;
  logic          redirect_act;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  fetch_entry_t  head;

  assign misaligned = !is_aligned(redirect_pc[1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = (redirect_valid && misaligned) ? ST_HALT : ST_RUN;
      ST_RUN:  if (redirect_valid && misaligned) state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // The slot freed by this cycle's pop counts as free, which is what lets a
  // two-entry buffer stream one instruction per cycle.
  always_comb begin
    redirect_act = redirect_valid && (state_q != ST_HALT);
    dec_valid    = !fifo_empty && (state_q != ST_HALT);
    fifo_pop     = dec_valid && dec_ready;
    occupancy    = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, fifo_pop};
    imem_req     = (state_q == ST_RUN) && !redirect_valid && (occupancy < (CW+1)'(BUF_DEPTH));
    fifo_push    = inflight_q && !redirect_act && (!fifo_full || fifo_pop);
    imem_addr    = fetch_pc_q;
    dec_instr    = dec_valid ? head.instr : '0;
    dec_pc       = dec_valid ? head.pc : '0;
    fault        = fault_q;
  end

  // A redirect never coincides with a request, so clearing inflight_q here
  // is what squashes the response due next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      inflight_q <= imem_req;
      req_pc_q   <= fetch_pc_q;
      if (redirect_act && !misaligned) fetch_pc_q <= redirect_pc;
      else if (imem_req)               fetch_pc_q <= fetch_pc_q + INSTR_BYTES;
      if (redirect_act && misaligned)  fault_q <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_act),
    .wdata ('{instr: imem_rdata, pc: req_pc_q}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus random
// decode stalls and redirects, compared each cycle against a queue-based model.
module tb_fetch_controller;
  import cpu_pkg::*;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] RPC     = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n, redirect_valid, dec_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, dec_valid, fault;
  logic [31:0] imem_addr, dec_instr, dec_pc;

  logic        w_req, w_valid, w_fault;
  logic [31:0] w_rdata, w_addr, w_instr, w_pc;

  int checks = 0;
  int errors = 0;
  int n_req  = 0;

  // Reference model state: buffer as queues, one optional in-flight fetch.
  bit          m_known, m_boot, m_halt, m_fault, m_infl;
  logic [31:0] m_pc, m_infl_pc;
  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];
  logic [31:0] w_log_pc[$];
  logic [31:0] w_log_instr[$];

  always #5 clk = ~clk;

  fetch_controller #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .fault(fault)
  );

  fetch_controller #(.RESET_PC(WRAP_PC), .BUF_DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst_n(rst_n), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .dec_valid(w_valid), .dec_ready(dec_ready), .dec_instr(w_instr),
    .dec_pc(w_pc), .fault(w_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #2;
  endtask

  // One clock cycle: compare against the model, clock, advance model, answer memory.
  task automatic step();
    bit          e_valid, e_req, pop, d_req, dw_req;
    logic [31:0] e_instr, e_pc, d_addr, dw_addr;
    #2;
    e_valid = !m_halt && (q_pc.size() > 0);
    e_instr = e_valid ? q_instr[0] : 32'h0;
    e_pc    = e_valid ? q_pc[0] : 32'h0;
    pop     = e_valid && dec_ready;
    e_req   = !m_boot && !m_halt && !redirect_valid &&
              ((q_pc.size() - int'(pop) + int'(m_infl)) < DEPTH);
    if (m_known) begin
      check("imem_req",  imem_req,  e_req);
      check("imem_addr", imem_addr, m_pc);
      check("dec_valid", dec_valid, e_valid);
      check("dec_instr", dec_instr, e_instr);
      check("dec_pc",    dec_pc,    e_pc);
      check("fault",     fault,     m_fault);
    end
    d_req   = imem_req;
    d_addr  = imem_addr;
    dw_req  = w_req;
    dw_addr = w_addr;
    if (imem_req) n_req++;
    if (w_valid && dec_ready) begin
      w_log_pc.push_back(w_pc);
      w_log_instr.push_back(w_instr);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_known = 1; m_boot = 1; m_halt = 0; m_fault = 0; m_infl = 0; m_pc = RPC;
      q_instr.delete(); q_pc.delete();
    end else if (m_halt) begin
      m_infl = 0;
    end else if (redirect_valid) begin
      q_instr.delete(); q_pc.delete();
      m_infl = 0;
      if (redirect_pc[1:0] == 2'b00) begin
        m_pc = redirect_pc; m_boot = 0;
      end else begin
        m_halt = 1; m_fault = 1;
      end
    end else begin
      if (pop) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (m_infl) begin
        q_instr.push_back(mem_word(m_infl_pc));
        q_pc.push_back(m_infl_pc);
      end
      m_infl    = e_req;
      m_infl_pc = m_pc;
      if (e_req) m_pc = m_pc + 32'd4;
      m_boot = 0;
    end
    #1;
    imem_rdata = d_req  ? mem_word(d_addr)  : $urandom();
    w_rdata    = dw_req ? mem_word(dw_addr) : $urandom();
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b1;
    imem_rdata = 32'h0; w_rdata = 32'h0;
    m_known = 0; m_boot = 1; m_halt = 0; m_fault = 0; m_infl = 0; m_pc = RPC; m_infl_pc = RPC;
    @(posedge clk); #1;

    // Reset, then steady streaming with decode always ready.
    repeat (3) step();
    settle();
    check("rst_req",   imem_req,  0);
    check("rst_addr",  imem_addr, RPC);
    check("rst_valid", dec_valid, 0);
    check("rst_instr", dec_instr, 0);
    check("rst_pc",    dec_pc,    0);
    check("rst_fault", fault,     0);
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 7; k++) begin
      settle();
      check("run_req",  imem_req,  1);
      check("run_addr", imem_addr, 32'(4 * k));
      if (k >= 2) begin
        check("run_valid", dec_valid, 1);
        check("run_pc",    dec_pc,    32'(4 * (k - 2)));
      end
      step();
    end
    check("wrap_cnt", (w_log_pc.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
    if (w_log_pc.size() >= 2) begin
      check("wrap_pc0",    w_log_pc[0],    WRAP_PC);
      check("wrap_pc1",    w_log_pc[1],    32'h0000_0000);
      check("wrap_instr0", w_log_instr[0], mem_word(WRAP_PC));
    end

    // Backpressure from a fresh reset: exactly DEPTH requests, then stall.
    rst_n = 1'b0; dec_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    n_req = 0;
    repeat (6) step();
    check("bp_reqs", 32'(n_req), 32'(DEPTH));
    settle();
    check("bp_idle", imem_req, 0);
    check("bp_head", dec_pc,   32'h0);
    dec_ready = 1'b1;
    repeat (8) step();

    // Redirect while the buffer is full and decode pops.
    dec_ready = 1'b0;
    repeat (4) step();
    settle();
    check("full_valid", dec_valid, 1);
    check("full_req",   imem_req,  0);
    redirect_valid = 1'b1; redirect_pc = 32'h20; dec_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    settle();
    check("rd_addr",  imem_addr, 32'h20);
    check("rd_req",   imem_req,  1);
    check("rd_empty", dec_valid, 0);
    step();
    settle();
    check("rd_stale", dec_valid, 0);
    step();
    settle();
    check("rd_valid", dec_valid, 1);
    check("rd_pc",    dec_pc,    32'h20);
    check("rd_instr", dec_instr, mem_word(32'h20));
    step();

    // Redirect coinciding with a pop and a returning word.
    repeat (4) step();
    settle();
    check("sim_valid", dec_valid, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    settle();
    check("sim_empty", dec_valid, 0);
    check("sim_addr",  imem_addr, 32'h100);
    repeat (4) step();

    // Random decode stalls and aligned redirects.
    for (int i = 0; i < 300; i++) begin
      dec_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom() & 32'hFFFF_FFFC;
      step();
    end
    redirect_valid = 1'b0; dec_ready = 1'b1;
    repeat (3) step();

    // Misaligned redirect: fault, halt, ignore later redirects, recover by reset.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0006;
    step();
    redirect_valid = 1'b0;
    settle();
    check("flt_fault", fault,     1);
    check("flt_req",   imem_req,  0);
    check("flt_valid", dec_valid, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    repeat (3) step();
    redirect_valid = 1'b0;
    settle();
    check("halt_fault", fault,     1);
    check("halt_req",   imem_req,  0);
    check("halt_valid", dec_valid, 0);
    rst_n = 1'b0;
    step();
    settle();
    check("rec_fault", fault,     0);
    check("rec_addr",  imem_addr, RPC);
    rst_n = 1'b1;
    step();
    settle();
    check("rec_req",  imem_req,  1);
    check("rec_addr", imem_addr, RPC);
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning fetch buffer entries (legal 2..4).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have port redirect_valid  in  1  branch/jump taken this cycle.
REQ-006 SHALL have port redirect_pc  in  32  byte-address target of the redirect.
REQ-007 SHALL have port imem_req  out  1  fetch request to instruction memory.
REQ-008 SHALL have port imem_addr  out  32  byte address of the request; memory indexes word imem_addr/4.
REQ-009 SHALL have port imem_rdata  in  32  instruction word, valid exactly 1 cycle after an accepted imem_req.
REQ-010 SHALL have port dec_valid  out  1  buffer head holds an instruction for decode.
REQ-011 SHALL have port dec_ready  in  1  decode consumes the head when dec_valid and dec_ready are both 1.
REQ-012 SHALL have port dec_instr  out  32  head instruction word.
REQ-013 SHALL have port dec_pc  out  32  byte address of dec_instr.
REQ-014 SHALL have port fault  out  1  sticky misaligned-target flag.

Function
REQ-015 SHALL implement FSM states BOOT, RUN, HALT; BOOT lasts one cycle after reset release, then RUN.
REQ-016 SHALL, in RUN, assert imem_req only when (buffer occupancy + in-flight count) < BUF_DEPTH and redirect_valid is 0.
REQ-017 SHALL drive imem_addr = fetch_pc and advance fetch_pc by 4 in each cycle imem_req is 1; fetch_pc wraps modulo 2^32.
REQ-018 SHALL write imem_rdata with its request address into the buffer one cycle after the request unless that request was squashed.
REQ-019 SHALL present the buffer head on dec_instr/dec_pc combinationally from registered storage, dec_valid = buffer non-empty.
REQ-020 SHALL allow, in one cycle, a write of a returning word and a pop by decode; occupancy then stays unchanged, including when full.
REQ-021 SHALL, on redirect_valid=1 with redirect_pc[1:0]=0: flush the buffer, squash any in-flight response, set fetch_pc=redirect_pc, issue no request that cycle; the first request to redirect_pc occurs the next cycle.
REQ-022 SHALL give redirect priority over a simultaneous decode pop or returning word; the popped/returning word is discarded.
REQ-023 SHALL, on redirect_valid=1 with redirect_pc[1:0]!=0: set fault=1, flush, squash, enter HALT.
REQ-024 SHALL, in HALT, hold imem_req=0 and dec_valid=0, ignore redirects, and leave HALT only through reset.
REQ-025 SHALL produce redirect-to-first-dec_valid latency of exactly 2 cycles when decode is ready.
REQ-026 SHALL sustain one instruction per cycle to decode when dec_ready is held 1 and no redirect occurs.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge: state=BOOT, fetch_pc=RESET_PC, buffer empty, in-flight cleared, fault=0.
REQ-028 SHALL drive outputs during and immediately after reset as imem_req=0, imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, fault=0.
REQ-029 SHALL treat reset asserted mid-operation as aborting all in-flight fetches; a response arriving in the following cycle is dropped.

Structure
REQ-030 SHALL place RESET_PC default, INSTR_BYTES (4), and the FSM state encoding in shared package cpu_pkg.
REQ-031 SHALL implement the buffer as sub-module fetch_fifo (parameter DEPTH, 32-bit instr + 32-bit pc, push/pop/flush, full/empty, count).

Verification
REQ-032 SHALL check reset to steady run: rst_n low 3 cycles, dec_ready=1 -> imem_addr 0,4,8,... from BOOT+1; dec_pc 0,4,8 on consecutive cycles.
REQ-033 SHALL check backpressure: dec_ready=0 for 5 cycles -> exactly BUF_DEPTH requests issued, then imem_req=0; on release no word lost or duplicated.
REQ-034 SHALL check redirect: redirect_valid=1, redirect_pc=32'h20 while buffer full -> next cycle imem_addr=32'h20; 2 cycles later dec_pc=32'h20; no stale instruction appears.
REQ-035 SHALL check simultaneous events: redirect coinciding with a decode pop and a returning word -> both discarded, occupancy 0 next cycle.
REQ-036 SHALL check fault: redirect_pc=32'h0000_0006 -> fault=1 next cycle, HALT; later redirect to 32'h10 ignored; rst_n low -> fault=0, fetch restarts at RESET_PC.
REQ-037 SHALL check wrap-around: RESET_PC=32'hFFFF_FFFC -> dec_pc FFFF_FFFC followed by 0000_0000.
